// File: rtl/routine_sequencer.sv
// routine_sequencer
//   Cycles through four display routines. Each routine gets a one-cycle
//   restart pulse, then runs until it reports done, is skipped, or hits the
//   watchdog limit. The outputs are then blanked for a fixed interval before
//   the next routine is selected.
//
// Ports
//   Clock         rising-edge clock for all state
//   Reset         synchronous active-high reset
//   Bus0..Bus3    routine buses: [46] done, [45:28] LED, [27:21] Hex3,
//                 [20:14] Hex2, [13:7] Hex1, [6:0] Hex0
//   Hold          level; freezes sequencing while running
//   Skip          single-cycle pulse; forces an advance while running
//   Led           registered LED field of the selected routine
//   Hex3..Hex0    registered seven-segment fields (7'h7F = all off)
//   RoutineSel    index of the current routine
//   RoutineReset  restart pulse to the routines
//   Blanking      high while outputs are blanked
//
// State table
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_RESTART | one cycle, RoutineReset=1, run counter cleared
//   ST_RUN     | routine active, counter counts non-held cycles
//   ST_BLANK   | outputs blanked for BLANK_CYCLES, then select next routine

module routine_sequencer #(
    parameter int BLANK_CYCLES = 4,
    parameter int MAX_CYCLES   = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [46:0] Bus0,
    input  logic [46:0] Bus1,
    input  logic [46:0] Bus2,
    input  logic [46:0] Bus3,
    input  logic        Hold,
    input  logic        Skip,
    output logic [17:0] Led,
    output logic [6:0]  Hex3,
    output logic [6:0]  Hex2,
    output logic [6:0]  Hex1,
    output logic [6:0]  Hex0,
    output logic [1:0]  RoutineSel,
    output logic        RoutineReset,
    output logic        Blanking
);

    typedef enum logic [1:0] {
        ST_RESTART = 2'd0,
        ST_RUN     = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    localparam logic [15:0] WD_LAST    = 16'(MAX_CYCLES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);
    localparam logic [6:0]  HEX_OFF    = 7'h7F;

    state_t      state, state_d;
    logic [15:0] run_cnt, run_cnt_d;
    logic [7:0]  blank_cnt, blank_cnt_d;
    logic [1:0]  sel_d;
    logic [46:0] bus_arr [4];
    logic        done_cur;
    logic [46:0] bus_nxt;

    assign bus_arr[0] = Bus0;
    assign bus_arr[1] = Bus1;
    assign bus_arr[2] = Bus2;
    assign bus_arr[3] = Bus3;

    assign done_cur = bus_arr[RoutineSel][46];
    // Output registers follow the routine that will be selected after the
    // edge, so Led/Hex line up with RoutineSel in the same cycle.
    assign bus_nxt  = bus_arr[sel_d];

    // State register and registered display outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_RESTART;
            RoutineSel <= 2'd0;
            run_cnt    <= 16'd0;
            blank_cnt  <= 8'd0;
            Led        <= 18'h00000;
            Hex3       <= HEX_OFF;
            Hex2       <= HEX_OFF;
            Hex1       <= HEX_OFF;
            Hex0       <= HEX_OFF;
        end else begin
            state      <= state_d;
            RoutineSel <= sel_d;
            run_cnt    <= run_cnt_d;
            blank_cnt  <= blank_cnt_d;
            if (state_d == ST_BLANK) begin
                Led  <= 18'h00000;
                Hex3 <= HEX_OFF;
                Hex2 <= HEX_OFF;
                Hex1 <= HEX_OFF;
                Hex0 <= HEX_OFF;
            end else begin
                Led  <= bus_nxt[45:28];
                Hex3 <= bus_nxt[27:21];
                Hex2 <= bus_nxt[20:14];
                Hex1 <= bus_nxt[13:7];
                Hex0 <= bus_nxt[6:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state;
        run_cnt_d   = run_cnt;
        blank_cnt_d = blank_cnt;
        sel_d       = RoutineSel;
        case (state)
            ST_RESTART: begin
                state_d   = ST_RUN;
                run_cnt_d = 16'd0;
            end
            ST_RUN: begin
                // Hold masks every advance cause; a Skip seen under Hold is lost.
                if (!Hold) begin
                    if (done_cur || Skip || (run_cnt == WD_LAST)) begin
                        state_d     = ST_BLANK;
                        run_cnt_d   = 16'd0;
                        blank_cnt_d = BLANK_LAST;
                    end else begin
                        run_cnt_d = run_cnt + 16'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_cnt == 8'd0) begin
                    state_d = ST_RESTART;
                    sel_d   = RoutineSel + 2'd1;
                end else begin
                    blank_cnt_d = blank_cnt - 8'd1;
                end
            end
            default: begin
                state_d = ST_RESTART;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        RoutineReset = (state == ST_RESTART);
        Blanking     = (state == ST_BLANK);
    end

endmodule

// File: doc/routine_sequencer.md
ROUTINE_SEQUENCER -- requirements
Module: routine_sequencer

Interface
REQ-001 The block SHALL have these parameters:
  - BLANK_CYCLES, 4, cycles of blanked output between routines (1..255)
  - MAX_CYCLES, 64, watchdog limit on RUN cycles per routine (2..65535)
REQ-002 The block SHALL have these ports, with one clock and a synchronous, active-high reset:
  - Clock  in  1  rising-edge clock for all state
  - Reset  in  1  synchronous active-high reset
  - Bus0..Bus3  in  47 each  routine output buses: [46] done, [45:28] LED field, [27:21] Hex3, [20:14] Hex2, [13:7] Hex1, [6:0] Hex0
  - Hold  in  1  level; freezes sequencing
  - Skip  in  1  single-cycle pulse; forces advance
  - Led  out  18  registered LED field of the selected routine
  - Hex3, Hex2, Hex1, Hex0  out  7 each  registered seven-segment fields
  - RoutineSel  out  2  index of the current routine
  - RoutineReset  out  1  restart pulse to the routines
  - Blanking  out  1  high in the BLANK state

Function
REQ-003 The FSM SHALL have three states: RESTART, RUN and BLANK.
REQ-004 RESTART SHALL last exactly one cycle, SHALL drive RoutineReset=1, and SHALL go to RUN with the cycle counter cleared to 0.
REQ-005 RoutineReset SHALL be 0 in every state except RESTART.
REQ-006 In RUN, while Hold=0, the counter SHALL increment by 1 each cycle.
REQ-007 RUN SHALL go to BLANK on the first cycle in which Hold=0 and any of these is true: Bus[RoutineSel][46]=1, Skip=1, or counter==MAX_CYCLES-1.
REQ-008 When several advance causes occur in the same cycle, the block SHALL perform exactly one advance.
REQ-009 While Hold=1 in RUN, the counter SHALL freeze, and done, Skip and the watchdog SHALL be ignored; a Skip pulse during Hold SHALL be discarded, not queued.
REQ-010 The done bit and Skip SHALL be ignored during RESTART and BLANK.
REQ-011 On entry to BLANK, the counter SHALL clear.
REQ-012 BLANK SHALL last exactly BLANK_CYCLES cycles and SHALL be unaffected by Hold.
REQ-013 On the last BLANK cycle, RoutineSel SHALL increment modulo 4 (3 wraps to 0) and the FSM SHALL go to RESTART.
REQ-014 In RUN and RESTART, Led and Hex3..Hex0 SHALL equal the corresponding fields of Bus[RoutineSel] sampled on the previous rising edge (one-cycle latency).
REQ-015 In BLANK, the block SHALL drive Led=18'h00000 and each Hex=7'h7F (all segments off), with the same one-cycle registration.
REQ-016 Blanking SHALL be combinational from the state register and SHALL equal 1 exactly in BLANK.
REQ-017 The counter SHALL be 16 bits wide and SHALL never wrap, because the watchdog advances before overflow.
REQ-018 The period from one RoutineReset pulse to the next SHALL be 1 + R + BLANK_CYCLES cycles, where R is the number of RUN cycles.

Reset
REQ-019 When Reset=1 is sampled on a rising edge, the block SHALL set the state to RESTART, RoutineSel to 0, the counter to 0, Led to 0 and each Hex to 7'h7F, regardless of the current state.
REQ-020 In the first cycle after Reset deasserts, RoutineReset SHALL be 1.
REQ-021 While Reset remains asserted, the state SHALL stay in RESTART and RoutineReset SHALL stay 1.
REQ-022 A reset applied during RUN or BLANK SHALL abandon the current routine, and sequencing SHALL restart from routine 0.

Verification
REQ-023 Scenario 1: reset, then Bus0[46] pulsed on RUN cycle 28 -> RoutineReset high 1 cycle; Led tracks Bus0[45:28] with 1-cycle lag; Blanking high for 4 cycles; RoutineSel=1; next RoutineReset on cycle 1+29+4=34.
REQ-024 Scenario 2: all done bits held at 0, MAX_CYCLES=64 -> each routine advances after 64 RUN cycles; RoutineSel goes 0,1,2,3,0 with period 69 cycles.
REQ-025 Scenario 3: Hold=1 from RUN cycle 10 to 40, with a Skip pulse and a done pulse inside that window -> no advance, counter stays at 10, and advance occurs only on a done or Skip after Hold drops.
REQ-026 Scenario 4: done, Skip and watchdog all coincident on a single cycle -> exactly one advance; RoutineSel increments by 1, not 2.
REQ-027 Scenario 5: Reset asserted on the 2nd BLANK cycle while RoutineSel=2 -> next cycle is RESTART with RoutineSel=0, Led=0 and Hex=7'h7F.
REQ-028 Scenario 6: Skip pulsed during RESTART and during BLANK -> ignored; routine timing unchanged.
